// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the PC/exception register unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        EXC_OVF    = 2'd0,
        EXC_INV_OP = 2'd1,
        EXC_DIV0   = 2'd2,
        EXC_RSVD   = 2'd3
    } exc_code_e;

    typedef enum logic [1:0] {
        EXC_IDLE   = 2'd0,
        EXC_SAVE   = 2'd1,
        EXC_VECTOR = 2'd2
    } exc_state_e;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch-taken evaluation from ALU flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (br_type_e'(br_type))
            BR_BEQ:  take = alu_zero;
            BR_BNE:  take = !alu_zero;
            BR_BLE:  take = alu_zero | alu_neg;
            BR_BGT:  take = !alu_zero & !alu_neg;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_reg_unit.sv
// rtl/pc_reg_unit.sv - PC/EPC/cause registers with 3-state exception sequencer.
// Optional PC_ALIGN_CHECK_EN: misaligned pc_in writes raise cause 3 instead of loading.
module pc_reg_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned EPC_OFFSET = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  br_type,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    input  logic        epc_restore,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [1:0]  cause_out,
    output logic        exc_sel,
    output logic        exc_busy,
    output logic        pc_wr_fire
);

    localparam logic [31:0] EPC_OFF = 32'(EPC_OFFSET);

    exc_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [1:0]  pend_cause_q, pend_cause_d;
    logic        exc_sel_q, exc_sel_d;
    logic        exc_busy_q, exc_busy_d;
    logic        pc_wr_fire_q, pc_wr_fire_d;
    logic        take;
    logic        wr_req;

    branch_cond u_branch_cond (
        .br_type  (br_type),
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .take     (take)
    );

    assign wr_req = pc_write | (pc_write_cond & take);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        pend_cause_d = pend_cause_q;
        pc_wr_fire_d = 1'b0;
        case (state_q)
            EXC_IDLE: begin
                if (exc_req) begin
                    state_d      = EXC_SAVE;
                    pend_cause_d = exc_code;
                end else if (epc_restore) begin
                    pc_d         = epc_q;
                    pc_wr_fire_d = 1'b1;
                end else if (wr_req) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        state_d      = EXC_SAVE;
                        pend_cause_d = EXC_RSVD;
                    end else begin
                        pc_d         = pc_in;
                        pc_wr_fire_d = 1'b1;
                    end
`else
                    pc_d         = pc_in;
                    pc_wr_fire_d = 1'b1;
`endif
                end
            end
            EXC_SAVE: begin
                // PC is held here so EPC derives from the faulting instruction's PC.
                epc_d   = pc_q - EPC_OFF;
                cause_d = pend_cause_q;
                state_d = EXC_VECTOR;
            end
            EXC_VECTOR: begin
                pc_d         = pc_in;
                pc_wr_fire_d = 1'b1;
                state_d      = EXC_IDLE;
            end
            default: state_d = EXC_IDLE;
        endcase
        exc_sel_d  = (state_d == EXC_VECTOR);
        exc_busy_d = (state_d != EXC_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EXC_IDLE;
            pc_q         <= RESET_PC;
            epc_q        <= 32'h0;
            cause_q      <= 2'b00;
            pend_cause_q <= 2'b00;
            exc_sel_q    <= 1'b0;
            exc_busy_q   <= 1'b0;
            pc_wr_fire_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            pend_cause_q <= pend_cause_d;
            exc_sel_q    <= exc_sel_d;
            exc_busy_q   <= exc_busy_d;
            pc_wr_fire_q <= pc_wr_fire_d;
        end
    end

    assign pc_out     = pc_q;
    assign epc_out    = epc_q;
    assign cause_out  = cause_q;
    assign exc_sel    = exc_sel_q;
    assign exc_busy   = exc_busy_q;
    assign pc_wr_fire = pc_wr_fire_q;

endmodule

// File: tb/tb_pc_reg_unit.sv
// tb/tb_pc_reg_unit.sv - directed self-checking bench for pc_reg_unit.
module tb_pc_reg_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] HANDLER = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic        pc_write = 1'b0;
    logic        pc_write_cond = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic        exc_req = 1'b0;
    logic [1:0]  exc_code = 2'b00;
    logic        epc_restore = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic [1:0]  cause_out;
    logic        exc_sel;
    logic        exc_busy;
    logic        pc_wr_fire;

    int n_checks = 0;
    int n_pass   = 0;

    pc_reg_unit #(
        .RESET_PC   (RST_PC),
        .EPC_OFFSET (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_in         (pc_in),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .br_type       (br_type),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .epc_restore   (epc_restore),
        .pc_out        (pc_out),
        .epc_out       (epc_out),
        .cause_out     (cause_out),
        .exc_sel       (exc_sel),
        .exc_busy      (exc_busy),
        .pc_wr_fire    (pc_wr_fire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        exc_req       = 1'b0;
        epc_restore   = 1'b0;
        alu_zero      = 1'b0;
        alu_neg       = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_in    = v;
        pc_write = 1'b1;
        step();
        pc_write = 1'b0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        check("rst_pc",    pc_out,     RST_PC);
        check("rst_epc",   epc_out,    32'h0);
        check("rst_cause", cause_out,  32'h0);
        check("rst_sel",   exc_sel,    32'h0);
        check("rst_busy",  exc_busy,   32'h0);
        check("rst_fire",  pc_wr_fire, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        pc_in = 32'h4; pc_write = 1'b1;
        step();
        check("wr_pc",   pc_out,     32'h4);
        check("wr_fire", pc_wr_fire, 32'h1);
        pc_write = 1'b0;
        step();
        check("wr_fire_pulse", pc_wr_fire, 32'h0);

        pc_write_cond = 1'b1; br_type = 2'b01; alu_zero = 1'b1; pc_in = 32'h40;
        step();
        check("bne_nt_pc",   pc_out,     32'h4);
        check("bne_nt_fire", pc_wr_fire, 32'h0);
        alu_zero = 1'b0;
        step();
        check("bne_t_pc",   pc_out,     32'h40);
        check("bne_t_fire", pc_wr_fire, 32'h1);
        br_type = 2'b10; alu_neg = 1'b1; pc_in = 32'h80;
        step();
        check("ble_neg_pc", pc_out, 32'h80);
        br_type = 2'b11; pc_in = 32'h90;
        step();
        check("bgt_nt_pc", pc_out, 32'h80);
        alu_neg = 1'b0;
        step();
        check("bgt_t_pc", pc_out, 32'h90);
        br_type = 2'b00; pc_in = 32'hA0;
        step();
        check("beq_nt_pc", pc_out, 32'h90);
        clear_inputs();

        load_pc(32'h108);
        exc_req = 1'b1; exc_code = 2'd0; pc_write = 1'b1; pc_in = 32'h200;
        step();
        check("save_pc",   pc_out,   32'h108);
        check("save_busy", exc_busy, 32'h1);
        check("save_sel",  exc_sel,  32'h0);
        exc_req = 1'b0; exc_code = 2'd2; pc_in = 32'h300;
        step();
        check("vec_epc",   epc_out,   32'h104);
        check("vec_cause", cause_out, 32'h0);
        check("vec_sel",   exc_sel,   32'h1);
        check("vec_pc",    pc_out,    32'h108);
        pc_in = HANDLER;
        step();
        check("hnd_pc",   pc_out,     HANDLER);
        check("hnd_fire", pc_wr_fire, 32'h1);
        check("hnd_busy", exc_busy,   32'h0);
        check("hnd_sel",  exc_sel,    32'h0);
        clear_inputs();

        epc_restore = 1'b1;
        step();
        check("rest_pc",   pc_out,     32'h104);
        check("rest_fire", pc_wr_fire, 32'h1);
        epc_restore = 1'b0;
        load_pc(32'h500);
        epc_restore = 1'b1; exc_req = 1'b1; exc_code = 2'd2;
        step();
        check("prio_pc",   pc_out,   32'h500);
        check("prio_busy", exc_busy, 32'h1);
        clear_inputs();
        step();
        check("prio_epc",   epc_out,   32'h4FC);
        check("prio_cause", cause_out, 32'h2);
        pc_in = HANDLER;
        step();
        check("prio_hnd_pc", pc_out, HANDLER);

        load_pc(32'h0);
        exc_req = 1'b1; exc_code = 2'd1;
        step();
        exc_req = 1'b0;
        step();
        check("wrap_epc",   epc_out,   32'hFFFF_FFFC);
        check("wrap_cause", cause_out, 32'h1);
        pc_in = HANDLER;
        step();

        exc_req = 1'b1; exc_code = 2'd3;
        step();
        exc_req = 1'b0;
        step();
        check("abort_in_vec", exc_sel, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_pc",    pc_out,    RST_PC);
        check("abort_busy",  exc_busy,  32'h0);
        check("abort_sel",   exc_sel,   32'h0);
        check("abort_epc",   epc_out,   32'h0);
        check("abort_cause", cause_out, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        pc_in = 32'h1234;
        step();
        check("post_rst_pc",   pc_out,   RST_PC);
        check("post_rst_busy", exc_busy, 32'h0);

        pc_in = 32'h42; pc_write = 1'b1;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc",   pc_out,     RST_PC);
        check("align_busy", exc_busy,   32'h1);
        check("align_fire", pc_wr_fire, 32'h0);
        step();
        check("align_cause", cause_out, 32'h3);
        check("align_epc",   epc_out,   RST_PC - 32'h4);
        check("align_sel",   exc_sel,   32'h1);
        pc_in = HANDLER;
        step();
        check("align_hnd_pc", pc_out, HANDLER);
`else
        check("noalign_pc",    pc_out,     32'h42);
        check("noalign_fire",  pc_wr_fire, 32'h1);
        check("noalign_busy",  exc_busy,   32'h0);
        check("noalign_cause", cause_out,  32'h0);
`endif
        clear_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
